// File: rtl/axo_base.sv
// Shared definitions for the Axolotl integer datapath.
// Holds the RISC-V funct3 encodings that select the ALU operation.
package axo_base;

  localparam logic [2:0] RV_ALU_ADD  = 3'b000;  // ADD / SUB
  localparam logic [2:0] RV_ALU_SLL  = 3'b001;
  localparam logic [2:0] RV_ALU_SLT  = 3'b010;
  localparam logic [2:0] RV_ALU_SLTU = 3'b011;
  localparam logic [2:0] RV_ALU_XOR  = 3'b100;
  localparam logic [2:0] RV_ALU_SRL  = 3'b101;  // SRL / SRA
  localparam logic [2:0] RV_ALU_OR   = 3'b110;
  localparam logic [2:0] RV_ALU_AND  = 3'b111;

endpackage

// File: rtl/axo_shifter.sv
// Combinational barrel shifter for SLL / SRL / SRA.
// Ports:
//   data   - value to shift
//   shamt  - shift distance (low log2(XLEN) bits of operand b)
//   dir    - 0 = shift left, 1 = shift right
//   arith  - with dir=1, fill vacated bits with data's sign bit
//   result - shifted value
// Left shifts are done by bit-reversing the operand, shifting right and
// reversing back, so a single right-shifting ladder serves all three ops.
module axo_shifter #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] data,
  input  logic [SHW-1:0]  shamt,
  input  logic            dir,
  input  logic            arith,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] data_rev;
  logic [XLEN-1:0] shifted_next;
  logic [XLEN-1:0] shifted_rev;
  logic            fill;

  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_rev
      assign data_rev[gi]    = data[XLEN-1-gi];
      assign shifted_rev[gi] = shifted_next[XLEN-1-gi];
    end
  endgenerate

  // Sign fill only applies to right shifts.
  assign fill = arith & dir & data[XLEN-1];

  // Log-depth ladder: stage i shifts right by 2**i when shamt[i] is set.
  always_comb begin
    shifted_next = dir ? data : data_rev;
    for (int i = 0; i < SHW; i++) begin
      if (shamt[i]) begin
        if (fill) begin
          shifted_next = ~((~shifted_next) >> (2 ** i));
        end else begin
          shifted_next = shifted_next >> (2 ** i);
        end
      end
    end
  end

  assign result = dir ? shifted_next : shifted_rev;

endmodule

// File: rtl/axo_alu.sv
// RV32I integer ALU for the Axolotl execute stage (OP and OP-IMM).
// Ports:
//   clk    - core clock, rising edge
//   rst    - synchronous active-high reset, clears q
//   funct3 - operation select (RV_ALU_* encodings)
//   inst30 - instruction bit 30: SUB over ADD, SRA over SRL
//   is_imm - OP-IMM form; blocks SUB so ADDI never subtracts
//   a, b   - operands (b is rs2 or the sign-extended immediate)
//   q      - registered result, one cycle after the inputs
module axo_alu
  import axo_base::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      funct3,
  input  logic            inst30,
  input  logic            is_imm,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] q
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] q_reg;
  logic [XLEN-1:0] q_next;
  logic [XLEN-1:0] shift_result;
  logic            sub_sel;
  logic            shift_right;
  logic            lt_signed;
  logic            lt_unsigned;

  // OP-IMM has no SUBI; bit 30 of an ADDI is just immediate data.
  assign sub_sel     = inst30 & ~is_imm;
  assign shift_right = (funct3 == RV_ALU_SRL);
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  // SRAI keeps inst30 meaningful regardless of is_imm.
  axo_shifter #(
    .XLEN (XLEN)
  ) u_shifter (
    .data   (a),
    .shamt  (b[SHW-1:0]),
    .dir    (shift_right),
    .arith  (inst30),
    .result (shift_result)
  );

  always_comb begin
    q_next = '0;
    case (funct3)
      RV_ALU_ADD:  q_next = sub_sel ? (a - b) : (a + b);
      RV_ALU_SLL:  q_next = shift_result;
      RV_ALU_SLT:  q_next = {{(XLEN-1){1'b0}}, lt_signed};
      RV_ALU_SLTU: q_next = {{(XLEN-1){1'b0}}, lt_unsigned};
      RV_ALU_XOR:  q_next = a ^ b;
      RV_ALU_SRL:  q_next = shift_result;
      RV_ALU_OR:   q_next = a | b;
      RV_ALU_AND:  q_next = a & b;
      default:     q_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: tb/tb_axo_alu.sv
module tb_axo_alu;

  logic        clk;
  logic        rst;
  logic [2:0]  funct3;
  logic        inst30;
  logic        is_imm;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;

  int checks;
  int errors;

  axo_alu #(
    .XLEN (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .funct3 (funct3),
    .inst30 (inst30),
    .is_imm (is_imm),
    .a      (a),
    .b      (b),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: q=0x%08h", tag, got);
    end
  endtask

  // Reference model: the RV32I operation rules in plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic i30, input logic imm,
                                          input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    logic [31:0] r;
    sh = y % 32;
    case (f)
      3'd0: r = (i30 && !imm) ? x - y : x + y;
      3'd1: r = x << sh;
      3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: r = (x < y) ? 32'd1 : 32'd0;
      3'd4: r = x ^ y;
      3'd5: r = i30 ? 32'($signed(x) >>> sh) : (x >> sh);
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  // Apply one operation, clock it in, and compare q just after the edge.
  task automatic run_op(input string tag, input logic [2:0] f, input logic i30, input logic imm,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    funct3 = f;
    inst30 = i30;
    is_imm = imm;
    a      = x;
    b      = y;
    @(posedge clk);
    #1;
    check_eq(tag, q, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    funct3 = 3'd0;
    inst30 = 1'b0;
    is_imm = 1'b0;
    a      = 32'd3;
    b      = 32'd9;

    @(posedge clk);
    #1;
    check_eq("reset", q, 32'h0);
    rst = 1'b0;

    run_op("add",       3'd0, 1'b0, 1'b0, 32'd3, 32'd9, 32'h0000000C);
    run_op("addi_i30",  3'd0, 1'b1, 1'b1, 32'd3, 32'd9, 32'h0000000C);
    run_op("sub",       3'd0, 1'b1, 1'b0, 32'd3, 32'd9, 32'hFFFFFFFA);
    run_op("sll",       3'd1, 1'b0, 1'b0, 32'h0000C3C3, 32'd9,    32'h01878600);
    run_op("sll_hi_b",  3'd1, 1'b1, 1'b0, 32'h0000C3C3, 32'h29,   32'h01878600);
    run_op("sll_b32",   3'd1, 1'b0, 1'b0, 32'h0000C3C3, 32'd32,   32'h0000C3C3);
    run_op("srl",       3'd5, 1'b0, 1'b0, 32'hF00DBABE, 32'd12,   32'h000F00DB);
    run_op("sra",       3'd5, 1'b1, 1'b0, 32'hF00DBABE, 32'd12,   32'hFFFF00DB);
    run_op("srli",      3'd5, 1'b0, 1'b1, 32'hF00DBABE, 32'd12,   32'h000F00DB);
    run_op("srai",      3'd5, 1'b1, 1'b1, 32'hF00DBABE, 32'd12,   32'hFFFF00DB);
    run_op("sra_b33",   3'd5, 1'b1, 1'b0, 32'h80000000, 32'd33,   32'hC0000000);
    run_op("xor",       3'd4, 1'b0, 1'b0, 32'hCCCC3333, 32'h99996666, 32'h55555555);
    run_op("or",        3'd6, 1'b1, 1'b0, 32'hCCCC3333, 32'h99996666, 32'hDDDD7777);
    run_op("and",       3'd7, 1'b0, 1'b0, 32'hCCCC3333, 32'h99996666, 32'h88882222);
    run_op("slt",       3'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h1);
    run_op("sltu",      3'd3, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0);

    // Reset mid-stream: q first holds a non-zero ADD result, then clears.
    run_op("pre_rst",   3'd0, 1'b0, 1'b0, 32'd3, 32'd9, 32'h0000000C);
    rst = 1'b1;
    run_op("rst_mid",   3'd0, 1'b0, 1'b0, 32'd3, 32'd9, 32'h0);
    rst = 1'b0;
    run_op("post_rst",  3'd0, 1'b0, 1'b0, 32'd3, 32'd9, 32'h0000000C);

    // Randomized operations against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  rf;
      logic        ri30;
      logic        rimm;
      logic [31:0] ra;
      logic [31:0] rb;
      rf   = 3'($urandom_range(0, 7));
      ri30 = 1'($urandom_range(0, 1));
      rimm = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 40));
        1: ra = ra | 32'h80000000;
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d_i%0d_m%0d", i, rf, ri30, rimm), rf, ri30, rimm, ra, rb,
             ref_alu(rf, ri30, rimm, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axo_alu.md
Name: axo_alu

Overview:
- RV32I integer ALU for the Axolotl core's execute stage; computes OP and OP-IMM results from funct3, instruction bit 30 and an immediate-form flag.
- Result is registered: one clock of latency from operand/control to q.
- Operand muxing (rs2 vs immediate) happens upstream; this block only sees a and b.

Parameters:
- XLEN, 32, datapath width; shift amount is b[$clog2(XLEN)-1:0] (b[4:0] at 32).

Ports:
- clk  input  1  core clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- funct3  input  3  RISC-V funct3 operation select (RV_ALU_* encodings)
- inst30  input  1  instruction bit 30; selects SUB over ADD, and SRA over SRL
- is_imm  input  1  1 = OP-IMM form (ADDI etc.); suppresses SUB selection
- a  input  XLEN  operand 1 (rs1)
- b  input  XLEN  operand 2 (rs2 or sign-extended immediate)
- q  output  XLEN  registered result

Behaviour:
- Reset: on a rising clk edge with rst=1, q <= 0. Reset has priority over any operation; there is no further state.
- Otherwise, on every rising clk edge, q <= f(funct3, inst30, is_imm, a, b). There is no enable and no handshake; a new operation is accepted every cycle.
- Operation table (funct3):
  - 000 ADD/SUB: a+b, or a-b when inst30=1 and is_imm=0; modulo 2^XLEN, carry discarded.
  - 001 SLL: a << b[4:0], zero fill; inst30 ignored.
  - 010 SLT: {31'b0, signed(a) < signed(b)}.
  - 011 SLTU: {31'b0, a < b} unsigned.
  - 100 XOR: a ^ b.
  - 101 SRL/SRA: a >> b[4:0]; zero fill when inst30=0, sign (a[31]) fill when inst30=1. The is_imm value has no effect, so SRAI works.
  - 110 OR: a | b.
  - 111 AND: a & b.
- Shift amount:
  - Only the low 5 bits of b are used; upper bits are ignored (b=32 shifts by 0, b=33 by 1).
  - Shift by 0 returns a unchanged.
- inst30 is ignored for every funct3 except 000 and 101.
- Inputs are sampled only at the clock edge. Glitches between edges have no effect.

Decomposition:
- Shared header/package (axo_base): RV_ALU_ADD=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL=101, OR=110, AND=111.
- Sub-module axo_shifter: combinational barrel shifter with inputs data, shamt[4:0], dir, arith. It carries the SLL/SRL/SRA logic.
- Adder, compare and logic operations stay inline in axo_alu.

Test Plan:
- ADD: a=3, b=9, funct3=000, inst30=0, is_imm=0 -> q=0x0000000C one cycle later. Repeat with is_imm=1, inst30=1 -> q=0x0000000C (ADDI does not subtract).
- SUB: a=3, b=9, funct3=000, inst30=1, is_imm=0 -> q=0xFFFFFFFA (signed -6).
- SLL: a=0x0000C3C3, b=9 -> q=0x01878600. Also b=0x29 -> shift by 9, same result.
- SRL/SRA: a=0xF00DBABE, b=12:
  - inst30=0 -> q=0x000F00DB
  - inst30=1 -> q=0xFFFF00DB
  - same with is_imm=1, both results unchanged
- XOR/OR/AND: a=0xCCCC3333, b=0x99996666:
  - XOR -> 0x55555555
  - OR -> 0xDDDD7777
  - AND -> 0x88882222
- SLT/SLTU: a=0xFFFFFFFF, b=1:
  - SLT -> 1
  - SLTU -> 0
- Reset: assert rst=1 mid-stream while ADD inputs are applied -> q=0 after the edge. Deassert -> q shows the next result after one edge.
